// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a ready/valid data-memory handshake, store lane
// replication, load lane extraction and MEM/WB registers. Optional macro: MISALIGN_TRAP_EN.
`default_nettype none

module memory_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_ValidM,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  logic                     i_MemReadM,
    input  logic                     i_MemWriteM,
    input  logic [1:0]               i_MemSizeM,
    input  logic                     i_MemUnsignedM,
    input  logic [1:0]               i_MemtoRegM,
    input  logic                     i_RegWriteM,
    input  logic [4:0]               i_WriteRegM,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4M,
    output logic                     o_DMemReq,
    output logic                     o_DMemWe,
    output logic [ADDRESS_WIDTH-1:0] o_DMemAddr,
    output logic [DATA_WIDTH-1:0]    o_DMemWData,
    output logic [3:0]               o_DMemBe,
    input  logic                     i_DMemReady,
    input  logic [DATA_WIDTH-1:0]    i_DMemRData,
    output logic                     o_StallM,
    output logic                     o_ValidW,
    output logic [ADDRESS_WIDTH-1:0] o_ALUOutW,
    output logic [DATA_WIDTH-1:0]    o_ReadDataW,
    output logic [1:0]               o_MemtoRegW,
    output logic                     o_RegWriteW,
    output logic [4:0]               o_WriteRegW,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4W
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                     o_MisalignExcW
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;
    state_t state_q;

    // Request captured on entry to WAIT so the memory sees stable values while stalled
    logic [ADDRESS_WIDTH-1:0] addr_q, pcplus4_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [3:0]               be_q;
    logic                     we_q, load_q, uns_q, regwrite_q;
    logic [1:0]               size_q, memtoreg_q;
    logic [4:0]               writereg_q;

    logic                     validw_q, regwritew_q;
    logic [ADDRESS_WIDTH-1:0] aluoutw_q, pcplus4w_q;
    logic [DATA_WIDTH-1:0]    readdataw_q;
    logic [1:0]               memtoregw_q;
    logic [4:0]               writeregw_q;

    logic in_wait, mem_op, misalign, req, stall;
    logic validw_d, regwritew_d;
    logic [DATA_WIDTH-1:0] readdataw_d, cur_wdata, ld_data;
    logic [3:0] cur_be;
    logic [7:0] byte_v;
    logic [15:0] half_v;

    logic [ADDRESS_WIDTH-1:0] sel_addr, sel_pcplus4;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [3:0]               sel_be;
    logic                     sel_we, sel_load, sel_uns, sel_regwrite;
    logic [1:0]               sel_size, sel_memtoreg;
    logic [4:0]               sel_writereg;

    assign in_wait = (state_q == WAIT);
    assign mem_op  = i_ValidM & (i_MemReadM | i_MemWriteM);

`ifdef MISALIGN_TRAP_EN
    assign misalign = ~in_wait & mem_op &
                      (((i_MemSizeM == 2'b01) & i_ALUOutM[0]) |
                       (i_MemSizeM[1] & (i_ALUOutM[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign req   = ~i_RST & (in_wait | (mem_op & ~misalign));
    assign stall = req & ~i_DMemReady;

    always_comb begin
        cur_be    = 4'b1111;
        cur_wdata = i_WriteDataM;
        if (i_MemWriteM) begin
            case (i_MemSizeM)
                2'b00: begin
                    cur_be    = 4'b0001 << i_ALUOutM[1:0];
                    cur_wdata = {(DATA_WIDTH/8){i_WriteDataM[7:0]}};
                end
                2'b01: begin
                    cur_be    = i_ALUOutM[1] ? 4'b1100 : 4'b0011;
                    cur_wdata = {(DATA_WIDTH/16){i_WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign sel_addr     = in_wait ? addr_q     : i_ALUOutM;
    assign sel_pcplus4  = in_wait ? pcplus4_q  : i_PCPlus4M;
    assign sel_wdata    = in_wait ? wdata_q    : cur_wdata;
    assign sel_be       = in_wait ? be_q       : cur_be;
    assign sel_we       = in_wait ? we_q       : i_MemWriteM;
    assign sel_load     = in_wait ? load_q     : (i_MemReadM & ~i_MemWriteM);
    assign sel_uns      = in_wait ? uns_q      : i_MemUnsignedM;
    assign sel_size     = in_wait ? size_q     : i_MemSizeM;
    assign sel_regwrite = in_wait ? regwrite_q : i_RegWriteM;
    assign sel_memtoreg = in_wait ? memtoreg_q : i_MemtoRegM;
    assign sel_writereg = in_wait ? writereg_q : i_WriteRegM;

    assign byte_v = i_DMemRData[{sel_addr[1:0], 3'b000} +: 8];
    assign half_v = i_DMemRData[{sel_addr[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = i_DMemRData;
        case (sel_size)
            2'b00:   ld_data = {{(DATA_WIDTH-8){~sel_uns & byte_v[7]}}, byte_v};
            2'b01:   ld_data = {{(DATA_WIDTH-16){~sel_uns & half_v[15]}}, half_v};
            default: ;
        endcase
    end

    // A stalled cycle retires a bubble; a misaligned op retires without its register write
    assign validw_d    = ~stall & (in_wait | i_ValidM);
    assign regwritew_d = validw_d & sel_regwrite & ~misalign;
    assign readdataw_d = (~stall & req & sel_load) ? ld_data : '0;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pcplus4_q   <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            load_q      <= 1'b0;
            uns_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            size_q      <= '0;
            memtoreg_q  <= '0;
            writereg_q  <= '0;
            validw_q    <= 1'b0;
            regwritew_q <= 1'b0;
            aluoutw_q   <= '0;
            pcplus4w_q  <= '0;
            readdataw_q <= '0;
            memtoregw_q <= '0;
            writeregw_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall) begin
                        state_q    <= WAIT;
                        addr_q     <= i_ALUOutM;
                        pcplus4_q  <= i_PCPlus4M;
                        wdata_q    <= cur_wdata;
                        be_q       <= cur_be;
                        we_q       <= i_MemWriteM;
                        load_q     <= i_MemReadM & ~i_MemWriteM;
                        uns_q      <= i_MemUnsignedM;
                        regwrite_q <= i_RegWriteM;
                        size_q     <= i_MemSizeM;
                        memtoreg_q <= i_MemtoRegM;
                        writereg_q <= i_WriteRegM;
                    end
                end
                WAIT: begin
                    if (i_DMemReady) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            validw_q    <= validw_d;
            regwritew_q <= regwritew_d;
            aluoutw_q   <= sel_addr;
            pcplus4w_q  <= sel_pcplus4;
            readdataw_q <= readdataw_d;
            memtoregw_q <= sel_memtoreg;
            writeregw_q <= sel_writereg;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalignw_q;
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) misalignw_q <= 1'b0;
        else       misalignw_q <= misalign;
    end
    assign o_MisalignExcW = misalignw_q;
`endif

    assign o_DMemReq   = req;
    assign o_DMemWe    = req & sel_we;
    assign o_DMemBe    = req ? sel_be : 4'b0000;
    assign o_DMemAddr  = {sel_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign o_DMemWData = sel_wdata;
    assign o_StallM    = stall;

    assign o_ValidW    = validw_q;
    assign o_RegWriteW = regwritew_q;
    assign o_ALUOutW   = aluoutw_q;
    assign o_PCPlus4W  = pcplus4w_q;
    assign o_ReadDataW = readdataw_q;
    assign o_MemtoRegW = memtoregw_q;
    assign o_WriteRegW = writeregw_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
`default_nettype none

module tb_memory_stage;

    logic        clk, rst;
    logic        valid, rd, wr, uns, regw, ready;
    logic [31:0] alu, wdata, pc4, rdata;
    logic [1:0]  size, m2r;
    logic [4:0]  wreg;
    logic        req, we, stall, validw, regww;
    logic [31:0] daddr, dwdata, aluw, readw, pc4w;
    logic [3:0]  be;
    logic [1:0]  m2rw;
    logic [4:0]  wregw;
`ifdef MISALIGN_TRAP_EN
    logic        misw;
`endif
    int total = 0;
    int bad   = 0;

    memory_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .i_CLK(clk), .i_RST(rst), .i_ValidM(valid), .i_ALUOutM(alu),
        .i_WriteDataM(wdata), .i_MemReadM(rd), .i_MemWriteM(wr), .i_MemSizeM(size),
        .i_MemUnsignedM(uns), .i_MemtoRegM(m2r), .i_RegWriteM(regw), .i_WriteRegM(wreg),
        .i_PCPlus4M(pc4), .o_DMemReq(req), .o_DMemWe(we), .o_DMemAddr(daddr),
        .o_DMemWData(dwdata), .o_DMemBe(be), .i_DMemReady(ready), .i_DMemRData(rdata),
        .o_StallM(stall), .o_ValidW(validw), .o_ALUOutW(aluw), .o_ReadDataW(readw),
        .o_MemtoRegW(m2rw), .o_RegWriteW(regww), .o_WriteRegW(wregw), .o_PCPlus4W(pc4w)
`ifdef MISALIGN_TRAP_EN
        , .o_MisalignExcW(misw)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic v, input logic r, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d);
        valid = v; rd = r; wr = w; size = sz; uns = u; alu = a; wdata = d;
        regw = r; m2r = 2'b01; wreg = 5'd7; pc4 = 32'h1004;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ready = 1'b0; rdata = 32'h0;
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        total++; if ({validw, regww, readw, aluw} !== 66'd0) begin bad++; $display("FAIL rst_w got=%b %b %h %h exp=0", validw, regww, readw, aluw); end
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_lw;
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        ready = 1'b1; rdata = 32'hDEADBEEF; #1;
        total++; if ({req, stall, we, be} !== 7'b1_0_0_1111) begin bad++; $display("FAIL lw_req got=%b%b%b%b exp=1001111", req, stall, we, be); end
        total++; if (daddr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", daddr); end
        step();
        total++; if (readw !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", readw); end
        total++; if ({validw, regww, wregw, m2rw, pc4w} !== {1'b1, 1'b1, 5'd7, 2'b01, 32'h1004}) begin bad++; $display("FAIL lw_w got=%b %b %0d %b %h", validw, regww, wregw, m2rw, pc4w); end
    endtask

    task automatic test_byte_half_loads;
        rdata = 32'h80112233; ready = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0); step();
        total++; if (readw !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", readw); end
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0); step();
        total++; if (readw !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", readw); end
        set_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0); step();
        total++; if (readw !== 32'h00000022) begin bad++; $display("FAIL lb1 got=%h exp=00000022", readw); end
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0); step();
        total++; if (readw !== 32'hFFFF8011) begin bad++; $display("FAIL lh got=%h exp=ffff8011", readw); end
    endtask

    task automatic test_stores;
        ready = 1'b1;
        set_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD); #1;
        total++; if ({req, we, be} !== 6'b1_1_1100) begin bad++; $display("FAIL sh_be got=%b%b%b exp=111100", req, we, be); end
        total++; if ({daddr, dwdata} !== {32'h100, 32'hABCDABCD}) begin bad++; $display("FAIL sh_data got=%h %h exp=00000100 abcdabcd", daddr, dwdata); end
        step();
        total++; if ({validw, regww, readw} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL sh_w got=%b %b %h", validw, regww, readw); end
        set_op(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h12345677); #1;
        total++; if ({be, dwdata} !== {4'b0010, 32'h77777777}) begin bad++; $display("FAIL sb got=%b %h exp=0010 77777777", be, dwdata); end
        step();
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h108, 32'h01020304); #1;
        total++; if ({be, dwdata, daddr} !== {4'b1111, 32'h01020304, 32'h108}) begin bad++; $display("FAIL sw got=%b %h %h", be, dwdata, daddr); end
        step();
        set_op(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10C, 32'h5); rdata = 32'hFFFFFFFF; #1;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL both_we got=%b exp=1", we); end
        step();
        total++; if (readw !== 32'h0) begin bad++; $display("FAIL both_rd got=%h exp=0", readw); end
    endtask

    task automatic test_nonmem;
        ready = 1'b0;
        set_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0); regw = 1'b1; #1;
        total++; if ({req, stall, we, be} !== 7'b0) begin bad++; $display("FAIL alu_req got=%b%b%b%b exp=0000000", req, stall, we, be); end
        step();
        total++; if ({validw, regww, aluw, readw} !== {1'b1, 1'b1, 32'h55, 32'h0}) begin bad++; $display("FAIL alu_w got=%b %b %h %h", validw, regww, aluw, readw); end
        set_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0); #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL inv_req got=%b exp=0", req); end
        step();
        total++; if ({validw, regww} !== 2'b00) begin bad++; $display("FAIL inv_w got=%b%b exp=00", validw, regww); end
    endtask

    task automatic test_wait_store;
        ready = 1'b0;
        set_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D); #1;
        total++; if ({req, stall} !== 2'b11) begin bad++; $display("FAIL sw0_stall got=%b%b exp=11", req, stall); end
        for (int c = 1; c <= 3; c++) begin
            step();
            total++; if ({validw, regww} !== 2'b00) begin bad++; $display("FAIL sw_bubble%0d got=%b%b exp=00", c, validw, regww); end
            alu = 32'hFFF1; wdata = 32'h0; wr = 1'b0; rd = 1'b1; size = 2'b00; wreg = 5'd9;
            ready = (c == 3);
            #1;
            total++; if ({req, we, be, daddr, dwdata} !== {1'b1, 1'b1, 4'b1111, 32'h200, 32'hCAFEF00D}) begin bad++; $display("FAIL sw_hold%0d got=%b %b %b %h %h", c, req, we, be, daddr, dwdata); end
            total++; if (stall !== (c != 3)) begin bad++; $display("FAIL sw_stall%0d got=%b exp=%b", c, stall, c != 3); end
        end
        step();
        total++; if ({validw, wregw, aluw} !== {1'b1, 5'd7, 32'h200}) begin bad++; $display("FAIL sw_done got=%b %0d %h exp=1 7 00000200", validw, wregw, aluw); end
        valid = 1'b0; step();
    endtask

    task automatic test_wait_load;
        ready = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        step();
        alu = 32'h0; size = 2'b00; uns = 1'b0;
        ready = 1'b1; rdata = 32'h80112233;
        step();
        total++; if ({validw, regww, readw} !== {1'b1, 1'b1, 32'h00008011}) begin bad++; $display("FAIL lhu_wait got=%b %b %h exp=1 1 00008011", validw, regww, readw); end
        valid = 1'b0; step();
    endtask

    task automatic test_reset_in_wait;
        ready = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
        step();
        #1 rst = 1'b1;
        #1;
        total++; if ({req, stall} !== 2'b00) begin bad++; $display("FAIL rstw_drop got=%b%b exp=00", req, stall); end
        rst = 1'b0; valid = 1'b0;
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rstw_idle got=%b exp=0", req); end
        step();
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
        ready = 1'b1; rdata = 32'h11112222; #1;
        total++; if ({req, stall, daddr} !== {2'b10, 32'h304}) begin bad++; $display("FAIL rstw_lw got=%b%b %h", req, stall, daddr); end
        step();
        total++; if ({validw, readw} !== {1'b1, 32'h11112222}) begin bad++; $display("FAIL rstw_lwdone got=%b %h", validw, readw); end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign;
        ready = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0); #1;
        total++; if ({req, stall} !== 2'b00) begin bad++; $display("FAIL mis_req got=%b%b exp=00", req, stall); end
        step();
        total++; if ({misw, regww, validw} !== 3'b101) begin bad++; $display("FAIL mis_w got=%b%b%b exp=101", misw, regww, validw); end
        valid = 1'b0; step();
        total++; if (misw !== 1'b0) begin bad++; $display("FAIL mis_clr got=%b exp=0", misw); end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_byte_half_loads();
        test_stores();
        test_nonmem();
        test_wait_store();
        test_wait_load();
        test_reset_in_wait();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
